// File: rtl/st_frame_packetizer.sv
// Streams raw RGB pixels as Avalon-ST style video packets, with an optional 4-beat
// control packet per frame enabled by defining ST_FRAME_PACKETIZER_CTRL_PKT_EN.
module st_frame_packetizer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [23:0] in_data,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        frame_done
);

`ifdef ST_FRAME_PACKETIZER_CTRL_PKT_EN
    typedef enum logic [2:0] {
        CTRL_HDR = 3'd0,
        CTRL_B1  = 3'd1,
        CTRL_B2  = 3'd2,
        CTRL_B3  = 3'd3,
        VID_HDR  = 3'd4,
        PIX      = 3'd5
    } state_t;
    localparam state_t START = CTRL_HDR;

    localparam logic [15:0] W16 = 16'(FRAME_WIDTH);
    localparam logic [15:0] H16 = 16'(FRAME_HEIGHT);

    // Three symbols per beat, first symbol in the low byte lane
    function automatic logic [23:0] ctrl_word(input logic [3:0] s0, input logic [3:0] s1,
                                              input logic [3:0] s2);
        return {4'h0, s2, 4'h0, s1, 4'h0, s0};
    endfunction
`else
    typedef enum logic [2:0] {
        VID_HDR = 3'd4,
        PIX     = 3'd5
    } state_t;
    localparam state_t START = VID_HDR;
`endif

    localparam logic [15:0] COL_LAST = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(FRAME_HEIGHT - 1);

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [23:0] out_data_q, out_data_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic        out_fend_q, out_fend_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic        adv;
    logic        last_col;
    logic        last_row;

    assign adv      = !out_valid_q || out_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    assign in_ready          = (state_q == PIX) && adv;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    // out_fend_q marks a pixel eop, so the control packet's eop never fires this
    assign frame_done        = out_valid_q && out_ready && out_fend_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_fend_d  = out_fend_q;
        col_d       = col_q;
        row_d       = row_q;
        if (adv) begin
            out_sop_d  = 1'b0;
            out_eop_d  = 1'b0;
            out_fend_d = 1'b0;
            case (state_q)
`ifdef ST_FRAME_PACKETIZER_CTRL_PKT_EN
                CTRL_HDR: begin
                    out_valid_d = 1'b1;
                    out_data_d  = 24'h00000F;
                    out_sop_d   = 1'b1;
                    state_d     = CTRL_B1;
                end
                CTRL_B1: begin
                    out_valid_d = 1'b1;
                    out_data_d  = ctrl_word(W16[15:12], W16[11:8], W16[7:4]);
                    state_d     = CTRL_B2;
                end
                CTRL_B2: begin
                    out_valid_d = 1'b1;
                    out_data_d  = ctrl_word(W16[3:0], H16[15:12], H16[11:8]);
                    state_d     = CTRL_B3;
                end
                CTRL_B3: begin
                    out_valid_d = 1'b1;
                    out_data_d  = ctrl_word(H16[7:4], H16[3:0], 4'h3);
                    out_eop_d   = 1'b1;
                    state_d     = VID_HDR;
                end
`endif
                VID_HDR: begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_sop_d   = 1'b1;
                    state_d     = PIX;
                end
                PIX: begin
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        out_eop_d   = last_col && last_row;
                        out_fend_d  = last_col && last_row;
                        if (last_col) begin
                            col_d = '0;
                            if (last_row) begin
                                row_d   = '0;
                                state_d = START;
                            end else begin
                                row_d = row_q + 16'd1;
                            end
                        end else begin
                            col_d = col_q + 16'd1;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = START;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= START;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_fend_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_fend_q  <= out_fend_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

endmodule
